// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU control codes, sequencer states and slice op selects
package alu_pkg;

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_NOR = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_FINISH = 2'b10
  } state_t;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_SUM  = 2'b10;
  localparam logic [1:0] OP_LESS = 2'b11;

endpackage

// File: rtl/serial_alu_bit.sv
// rtl/serial_alu_bit.sv - combinational 1-bit ALU slice with operand inversion and carry
module serial_alu_bit
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       less,
  input  logic       a_inv,
  input  logic       b_inv,
  input  logic       cin,
  input  logic [1:0] op,
  output logic       res,
  output logic       cout
);

  logic a_eff;
  logic b_eff;

  assign a_eff = a ^ a_inv;
  assign b_eff = b ^ b_inv;
  assign cout  = (a_eff & b_eff) | (cin & (a_eff ^ b_eff));

  always_comb begin
    res = less;
    case (op)
      OP_AND:  res = a_eff & b_eff;
      OP_OR:   res = a_eff | b_eff;
      OP_SUM:  res = a_eff ^ b_eff ^ cin;
      default: res = less;
    endcase
  end

endmodule

// File: rtl/serial_alu_ctrl.sv
// rtl/serial_alu_ctrl.sv - bit-serial ALU sequencer, LSB-first over one slice
// Define SERIAL_ALU_ABORT_EN to add the abort input.
module serial_alu_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
`ifdef SERIAL_ALU_ABORT_EN
  input  logic             abort,
`endif
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             cout,
  output logic             overflow
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, sh_q, sh_d, result_q, result_d;
  logic [3:0]         ctrl_q, ctrl_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d, cout_raw_q, cout_raw_d, ovf_raw_q, ovf_raw_d;
  logic               set_q, set_d, zero_q, zero_d, cout_q, cout_d, ovf_q, ovf_d;
  logic               done_q, done_d;
  logic               slice_res, slice_cout, sum_msb;
  logic [WIDTH-1:0]   fin_res;
  logic               fin_cout, fin_ovf;

  serial_alu_bit u_bit (
    .a     (a_q[cnt_q]),
    .b     (b_q[cnt_q]),
    .less  (1'b0),
    .a_inv (ctrl_q[3]),
    .b_inv (ctrl_q[2]),
    .cin   (carry_q),
    .op    (ctrl_q[1:0]),
    .res   (slice_res),
    .cout  (slice_cout)
  );

  // SLT drives the slice with OP_LESS, so the MSB sum is rebuilt here for the set bit
  assign sum_msb = a_q[WIDTH-1] ^ ctrl_q[3] ^ b_q[WIDTH-1] ^ ctrl_q[2] ^ carry_q;

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    ctrl_d     = ctrl_q;
    cnt_d      = cnt_q;
    carry_d    = carry_q;
    sh_d       = sh_q;
    cout_raw_d = cout_raw_q;
    ovf_raw_d  = ovf_raw_q;
    set_d      = set_q;
    result_d   = result_q;
    zero_d     = zero_q;
    cout_d     = cout_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    fin_res    = '0;
    fin_cout   = 1'b0;
    fin_ovf    = 1'b0;

    case (ctrl_q)
      CTRL_AND, CTRL_OR, CTRL_NOR: fin_res = sh_q;
      CTRL_ADD, CTRL_SUB: begin
        fin_res  = sh_q;
        fin_cout = cout_raw_q;
        fin_ovf  = ovf_raw_q;
      end
      CTRL_SLT: begin
        fin_res  = {{(WIDTH-1){1'b0}}, set_q};
        fin_cout = cout_raw_q;
      end
      default: ;
    endcase

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = src1;
          b_d     = src2;
          ctrl_d  = alu_ctrl;
          cnt_d   = '0;
          carry_d = (alu_ctrl == CTRL_SUB) || (alu_ctrl == CTRL_SLT);
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sh_d    = {slice_res, sh_q[WIDTH-1:1]};
        carry_d = slice_cout;
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          cout_raw_d = slice_cout;
          ovf_raw_d  = carry_q ^ slice_cout;
          set_d      = sum_msb ^ (carry_q ^ slice_cout);
          state_d    = S_FINISH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_FINISH: begin
        result_d = fin_res;
        zero_d   = (fin_res == '0);
        cout_d   = fin_cout;
        ovf_d    = fin_ovf;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

`ifdef SERIAL_ALU_ABORT_EN
    if (abort && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      done_d   = 1'b0;
      result_d = result_q;
      zero_d   = zero_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      ctrl_q     <= '0;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      sh_q       <= '0;
      cout_raw_q <= 1'b0;
      ovf_raw_q  <= 1'b0;
      set_q      <= 1'b0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      cout_q     <= 1'b0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      ctrl_q     <= ctrl_d;
      cnt_q      <= cnt_d;
      carry_q    <= carry_d;
      sh_q       <= sh_d;
      cout_raw_q <= cout_raw_d;
      ovf_raw_q  <= ovf_raw_d;
      set_q      <= set_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      cout_q     <= cout_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  assign ready    = (state_q == S_IDLE);
  assign done     = done_q;
  assign result   = result_q;
  assign zero     = zero_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule
